// File: rtl/gtech_grant_split3.sv
// Three-way round-robin grant splitter: merges A/B/C into one upstream request and
// steers the returned grant to a single requester, with optional hold timeout.
module gtech_grant_split3 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic CP,
  input  logic CD,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic GI,
  output logic ZR,
  output logic ZA,
  output logic ZB,
  output logic ZC,
  output logic TO
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned REQ_N     = 3;
  localparam bit          HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  // Pointer encoding for the last winner.
  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REQ_N-1:0]   gnt_q, gnt_d;
  logic               zr_q, zr_d;
  logic               to_q, to_d;

  logic [REQ_N-1:0]   req;
  logic               any_req;
  logic               holder_req;
  logic [1:0]         win_idx;
  logic [REQ_N-1:0]   win_oh;

  assign req        = {C, B, A};
  assign any_req    = |req;
  assign holder_req = |(gnt_q & req);

  // Round-robin pick: search starts at the requester after the last winner.
  always_comb begin
    win_idx = IDX_A;
    case (ptr_q)
      IDX_A: begin
        if (req[1])      win_idx = IDX_B;
        else if (req[2]) win_idx = IDX_C;
        else             win_idx = IDX_A;
      end
      IDX_B: begin
        if (req[2])      win_idx = IDX_C;
        else if (req[0]) win_idx = IDX_A;
        else             win_idx = IDX_B;
      end
      default: begin
        if (req[0])      win_idx = IDX_A;
        else if (req[1]) win_idx = IDX_B;
        else             win_idx = IDX_C;
      end
    endcase
  end

  always_comb begin
    win_oh = 3'b000;
    case (win_idx)
      IDX_A:   win_oh = 3'b001;
      IDX_B:   win_oh = 3'b010;
      default: win_oh = 3'b100;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    zr_d    = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          state_d = ST_REQ;
          zr_d    = 1'b1;
        end
      end
      ST_REQ: begin
        gnt_d = '0;
        if (!any_req) begin
          state_d = ST_IDLE;
        end else if (GI) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          ptr_d   = win_idx;
          cnt_d   = '0;
        end else begin
          zr_d = 1'b1;
        end
      end
      ST_GRANT: begin
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        if (!holder_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
          // Release has priority, so TO only fires while the holder still requests.
          state_d = ST_IDLE;
          gnt_d   = '0;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_C;
      cnt_q   <= '0;
      gnt_q   <= '0;
      zr_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      zr_q    <= zr_d;
      to_q    <= to_d;
    end
  end

  assign ZR = zr_q;
  assign ZA = gnt_q[0];
  assign ZB = gnt_q[1];
  assign ZC = gnt_q[2];
  assign TO = to_q;

endmodule

// File: tb/tb_gtech_grant_split3.sv
// Bench for gtech_grant_split3: two instances (HOLD_MAX 4 and 3) share stimulus and
// are each checked every cycle against a transaction-level model.
module tb_gtech_grant_split3;

  localparam int unsigned H_U0 = 4;
  localparam int unsigned H_U1 = 3;

  logic CP, CD, A, B, C, GI;
  logic [1:0] zr_w, za_w, zb_w, zc_w, to_w;

  int total = 0;
  int bad   = 0;

  // Model state: current owner (-1 none), last winner, cycles held, pending request, timeout pulse.
  int m_owner[2];
  int m_last[2];
  int m_h[2];
  bit m_zr[2];
  bit m_to[2];

  gtech_grant_split3 #(.HOLD_MAX(H_U0)) u_h4 (
    .CP(CP), .CD(CD), .A(A), .B(B), .C(C), .GI(GI),
    .ZR(zr_w[0]), .ZA(za_w[0]), .ZB(zb_w[0]), .ZC(zc_w[0]), .TO(to_w[0])
  );

  gtech_grant_split3 #(.HOLD_MAX(H_U1)) u_h3 (
    .CP(CP), .CD(CD), .A(A), .B(B), .C(C), .GI(GI),
    .ZR(zr_w[1]), .ZA(za_w[1]), .ZB(zb_w[1]), .ZC(zc_w[1]), .TO(to_w[1])
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  function automatic int hold_of(input int i);
    return (i == 0) ? int'(H_U0) : int'(H_U1);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 2;
      m_h[i]     = 0;
      m_zr[i]    = 1'b0;
      m_to[i]    = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input logic [2:0] req, input logic gi);
    m_to[i] = 1'b0;
    if (m_owner[i] >= 0) begin
      if (!req[m_owner[i]]) begin
        m_owner[i] = -1;
      end else if (hold_of(i) != 0 && m_h[i] == hold_of(i)) begin
        m_owner[i] = -1;
        m_to[i]    = 1'b1;
      end else begin
        m_h[i]++;
      end
    end else if (m_zr[i]) begin
      if (req == 3'b000) begin
        m_zr[i] = 1'b0;
      end else if (gi) begin
        for (int k = 1; k <= 3; k++) begin
          int idx;
          idx = (m_last[i] + k) % 3;
          if (req[idx] && m_owner[i] < 0) m_owner[i] = idx;
        end
        m_last[i] = m_owner[i];
        m_h[i]    = 1;
        m_zr[i]   = 1'b0;
      end
    end else if (req != 3'b000) begin
      m_zr[i] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.ZR", i), int'(zr_w[i]), int'(m_zr[i]));
      check($sformatf("u%0d.ZA", i), int'(za_w[i]), int'(m_owner[i] == 0));
      check($sformatf("u%0d.ZB", i), int'(zb_w[i]), int'(m_owner[i] == 1));
      check($sformatf("u%0d.ZC", i), int'(zc_w[i]), int'(m_owner[i] == 2));
      check($sformatf("u%0d.TO", i), int'(to_w[i]), int'(m_to[i]));
    end
  endtask

  // Apply inputs, take one clock edge, advance the model, compare just after the edge.
  task automatic step(input logic a, input logic b, input logic c, input logic gi);
    A = a; B = b; C = c; GI = gi;
    @(posedge CP);
    for (int i = 0; i < 2; i++) begin
      if (!CD) model_reset();
      else     model_edge(i, {c, b, a}, gi);
    end
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    CD = 1'b0;
    #2;
    model_reset();
    CD = 1'b1;
  endtask

  int order[4];
  int ngr;
  int za_cnt, to_cnt;
  bit prev_z;

  initial begin
    CD = 1'b0; A = 1'b1; B = 1'b1; C = 1'b1; GI = 1'b0;
    model_reset();

    // Held in reset with all requests and GI toggling.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, (k % 2) == 1);
    check("rst_zr", int'(zr_w[0]), 0);
    check("rst_grants", int'({za_w[0], zb_w[0], zc_w[0]}), 0);
    check("rst_to", int'(to_w[0]), 0);
    #2 CD = 1'b1;

    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("first_req_zr", int'(zr_w[0]), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("first_grant_za", int'(za_w[0]), 1);
    check("first_grant_zr", int'(zr_w[0]), 0);
    idle(2);

    // Round-robin: all request, each owner drops for one cycle after its grant.
    pulse_reset();
    for (int k = 0; k < 4; k++) order[k] = -1;
    ngr = 0;
    prev_z = 1'b0;
    for (int n = 0; n < 40 && ngr < 4; n++) begin
      step(m_owner[0] != 0, m_owner[0] != 1, m_owner[0] != 2, m_zr[0]);
      if (prev_z)
        check("rr_turnaround", int'({zr_w[0], za_w[0], zb_w[0], zc_w[0]}), 0);
      prev_z = za_w[0] | zb_w[0] | zc_w[0];
      if (prev_z) begin
        order[ngr] = za_w[0] ? 0 : (zb_w[0] ? 1 : 2);
        ngr++;
      end
    end
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 2);
    check("rr_order3", order[3], 0);
    idle(3);

    // Request withdrawn before any grant, with and without GI on the same edge.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("wd_req", int'(zr_w[0]), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("wd_drop_zr", int'(zr_w[0]), 0);
    check("wd_no_grant", int'({za_w[0], zb_w[0], zc_w[0]}), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("wd_late_gi", int'({zr_w[0], za_w[0], zb_w[0], zc_w[0]}), 0);
    idle(2);

    // Timeout: A held, single GI pulse.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    za_cnt = int'(za_w[0]);
    to_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      za_cnt += int'(za_w[0]);
      to_cnt += int'(to_w[0]);
    end
    check("to_za_cycles", za_cnt, 4);
    check("to_pulses", to_cnt, 1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("to_next_b_u0", int'(zb_w[0]), 1);
    check("to_next_b_u1", int'(zb_w[1]), 1);
    idle(3);

    // Release and timeout on the same edge for the HOLD_MAX=3 instance.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("sim_zc_held", int'(zc_w[1]), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("sim_zc_drop", int'(zc_w[1]), 0);
    check("sim_to_quiet", int'(to_w[1]), 0);
    idle(2);

    // Asynchronous clear in the middle of a grant.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("ar_zb_before", int'(zb_w[0]), 1);
    #1 CD = 1'b0;
    #2;
    check("ar_zb_u0", int'(zb_w[0]), 0);
    check("ar_zb_u1", int'(zb_w[1]), 0);
    check("ar_zr_to", int'({zr_w, to_w}), 0);
    model_reset();
    #2 CD = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("ar_a_first_u0", int'(za_w[0]), 1);
    check("ar_a_first_u1", int'(za_w[1]), 1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
